// File: rtl/dvp_video_tx.sv
// rtl/dvp_video_tx.sv - DVP/CIS parallel video transmitter regenerating sensor frame/line timing
module dvp_video_tx #(
  parameter int DATA_W   = 10,
  parameter int PCLK_DIV = 2,
  parameter int HW       = 12,
  parameter int VW       = 11
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              enable_i,
  input  logic [HW-1:0]     h_active_i,
  input  logic [HW-1:0]     h_blank_i,
  input  logic [VW-1:0]     vsync_len_i,
  input  logic [VW-1:0]     v_back_i,
  input  logic [VW-1:0]     v_active_i,
  input  logic [VW-1:0]     v_front_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_sof_i,
  output logic              s_ready_o,
  output logic              pclk_o,
  output logic              href_o,
  output logic              vsync_o,
  output logic [DATA_W-1:0] d_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              underflow_o,
  output logic              sof_err_o
);

  localparam int DW = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;
  localparam logic [HW:0]   H_ONE = 1;
  localparam logic [VW-1:0] V_ONE = 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t        state, first_state, after_sync;
  logic [DW-1:0] div_cnt;
  logic [HW:0]   h_cnt, h_act, line_len, h_act_in, h_blank_in;
  logic [VW-1:0] v_cnt, vs_len, vb_len, va_len, vf_len, phase_len;
  logic          tick, line_end, phase_end, frame_end, active_slot, first_pix, load_cfg;

  assign h_act_in   = (h_active_i == '0) ? H_ONE : {1'b0, h_active_i};
  assign h_blank_in = (h_blank_i == '0) ? H_ONE : {1'b0, h_blank_i};

  // Zero-length vertical phases are skipped when choosing the next state.
  assign first_state = (vsync_len_i != '0) ? VSYNC : (v_back_i != '0) ? VBACK : ACTIVE;
  assign after_sync  = (vb_len != '0) ? VBACK : ACTIVE;

  always_comb begin
    phase_len = va_len;
    case (state)
      VSYNC:   phase_len = vs_len;
      VBACK:   phase_len = vb_len;
      VFRONT:  phase_len = vf_len;
      default: ;
    endcase
  end

  assign tick        = (div_cnt == DW'(PCLK_DIV - 1));
  assign line_end    = (h_cnt == line_len - H_ONE);
  assign phase_end   = line_end && (v_cnt == phase_len - V_ONE);
  assign frame_end   = tick && phase_end &&
                       ((state == VFRONT) || ((state == ACTIVE) && (vf_len == '0)));
  assign active_slot = (state == ACTIVE) && (h_cnt < h_act);
  assign first_pix   = (v_cnt == '0) && (h_cnt == '0);
  assign load_cfg    = enable_i && ((state == IDLE) || frame_end);

  assign s_ready_o = tick && active_slot;
  assign pclk_o    = (div_cnt >= DW'(PCLK_DIV / 2));
  assign busy_o    = (state != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      h_act    <= '0;
      line_len <= '0;
      vs_len   <= '0;
      vb_len   <= '0;
      va_len   <= '0;
      vf_len   <= '0;
    end else if (load_cfg) begin
      h_act    <= h_act_in;
      line_len <= h_act_in + h_blank_in;
      vs_len   <= vsync_len_i;
      vb_len   <= v_back_i;
      va_len   <= (v_active_i == '0) ? V_ONE : v_active_i;
      vf_len   <= v_front_i;
    end
  end

  // Counters point at the slot being prepared; its outputs are launched on the
  // tick edge, so the pad outputs trail the counters by one pixel period.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      href_o       <= 1'b0;
      vsync_o      <= 1'b0;
      d_o          <= '0;
      frame_done_o <= 1'b0;
      underflow_o  <= 1'b0;
      sof_err_o    <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        h_cnt   <= '0;
        v_cnt   <= '0;
        if (enable_i) state <= first_state;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          href_o  <= active_slot;
          vsync_o <= (state == VSYNC);
          d_o     <= (active_slot && s_valid_i) ? s_data_i : '0;
          if (active_slot && !s_valid_i) underflow_o <= 1'b1;
          if (s_ready_o && ((s_valid_i && (s_sof_i != first_pix)) || (s_sof_i && !first_pix)))
            sof_err_o <= 1'b1;
          if (!line_end) begin
            h_cnt <= h_cnt + 1'b1;
          end else begin
            h_cnt <= '0;
            if (!phase_end) begin
              v_cnt <= v_cnt + 1'b1;
            end else begin
              v_cnt <= '0;
              if (frame_end) begin
                frame_done_o <= 1'b1;
                state        <= enable_i ? first_state : IDLE;
              end else begin
                case (state)
                  VSYNC:   state <= after_sync;
                  VBACK:   state <= ACTIVE;
                  ACTIVE:  state <= VFRONT;
                  default: state <= IDLE;
                endcase
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_video_tx.sv
// tb/tb_dvp_video_tx.sv - self-checking bench for dvp_video_tx against a frame-position model
module tb_dvp_video_tx;
  localparam int DATA_W = 10, PCLK_DIV = 2, HW = 12, VW = 11;
  localparam int DIV = PCLK_DIV;

  logic              clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [HW-1:0]     h_active = '0, h_blank = '0;
  logic [VW-1:0]     vsync_len = '0, v_back = '0, v_active = '0, v_front = '0;
  logic              s_valid, s_sof;
  logic [DATA_W-1:0] s_data;
  logic              s_ready, pclk, href, vsync, busy, frame_done, underflow, sof_err;
  logic [DATA_W-1:0] d;

  dvp_video_tx #(.DATA_W(DATA_W), .PCLK_DIV(PCLK_DIV), .HW(HW), .VW(VW)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .enable_i(enable),
    .h_active_i(h_active), .h_blank_i(h_blank), .vsync_len_i(vsync_len),
    .v_back_i(v_back), .v_active_i(v_active), .v_front_i(v_front),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_sof_i(s_sof), .s_ready_o(s_ready),
    .pclk_o(pclk), .href_o(href), .vsync_o(vsync), .d_o(d), .busy_o(busy),
    .frame_done_o(frame_done), .underflow_o(underflow), .sof_err_o(sof_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int drop_idx = -1, bad_sof_idx = -1;
  int st_busy = 0, st_vs = 0, st_href = 0, st_done = 0;
  int cap[$];
  int b_busy, b_vs, b_href, b_done, b_cap;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit pix_valid(input int k); return k != drop_idx; endfunction
  function automatic bit pix_sof(input int k); return (k == 0) || (k == bad_sof_idx); endfunction
  function automatic int pix_val(input int k); return k + 1; endfunction

  // Pixel source: pixel k of the frame is presented until a ready slot takes it.
  int src_k = 0;
  bit src_take;
  initial begin
    s_valid = 1'b1; s_sof = 1'b1; s_data = 1;
    forever begin
      @(negedge clk);
      src_take = s_ready;
      @(posedge clk);
      #1;
      if (!rst_n) src_k = 0;
      else if (src_take) src_k = (src_k + 1) % ((int'(v_active) * int'(h_active) > 0) ?
                                                int'(v_active) * int'(h_active) : 1);
      s_valid = pix_valid(src_k);
      s_sof   = pix_sof(src_k);
      s_data  = DATA_W'(pix_val(src_k));
    end
  end

  // Model: frame position m_n in system clocks; slot q = m_n/DIV, line = q/L, column = q%L.
  bit m_run = 0, m_done = 0, m_uf = 0, m_se = 0;
  int m_n = 0, m_ha = 1, m_L = 2, m_vs = 0, m_vb = 0, m_va = 1, m_vf = 0, m_N = 2;

  task automatic snap_cfg();
    m_ha = (h_active == 0) ? 1 : int'(h_active);
    m_L  = m_ha + ((h_blank == 0) ? 1 : int'(h_blank));
    m_vs = int'(vsync_len); m_vb = int'(v_back); m_vf = int'(v_front);
    m_va = (v_active == 0) ? 1 : int'(v_active);
    m_N  = m_L * (m_vs + m_vb + m_va + m_vf);
  endtask

  task automatic slot_info(input int q, output bit vs, output bit act, output int pix);
    int line, col;
    line = q / m_L; col = q % m_L;
    vs   = line < m_vs;
    act  = (line >= m_vs + m_vb) && (line < m_vs + m_vb + m_va) && (col < m_ha);
    pix  = (line - m_vs - m_vb) * m_ha + col;
  endtask

  initial begin
    bit vs, act;
    int pix;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_n = 0; m_done = 0; m_uf = 0; m_se = 0;
      end else begin
        m_done = 0;
        if (!m_run) begin
          if (enable) begin m_run = 1; m_n = 0; snap_cfg(); end
        end else begin
          if (m_n % DIV == DIV - 1) begin
            slot_info(m_n / DIV, vs, act, pix);
            if (act && !pix_valid(pix)) m_uf = 1;
            if (act && ((pix_valid(pix) && (pix_sof(pix) != (pix == 0))) || (pix_sof(pix) && pix != 0)))
              m_se = 1;
          end
          if (m_n == DIV * m_N - 1) begin
            m_done = 1;
            if (enable) begin m_n = 0; snap_cfg(); end
            else m_run = 0;
          end else begin
            m_n++;
          end
        end
      end
    end
  end

  task automatic check_cycle();
    bit e_vs, e_act, n_vs, n_act;
    int e_pix, n_pix, e_d;
    e_vs = 0; e_act = 0; e_pix = 0; n_act = 0;
    if (m_run && m_n >= DIV) slot_info(m_n / DIV - 1, e_vs, e_act, e_pix);
    if (m_run) slot_info(m_n / DIV, n_vs, n_act, n_pix);
    e_d = (e_act && pix_valid(e_pix)) ? pix_val(e_pix) : 0;
    chk("pclk", int'(pclk), int'(m_run && (m_n % DIV >= DIV / 2)));
    chk("busy", int'(busy), int'(m_run));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("s_ready", int'(s_ready), int'(m_run && (m_n % DIV == DIV - 1) && n_act));
    chk("href", int'(href), int'(e_act));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("d", int'(d), e_d);
    chk("underflow", int'(underflow), int'(m_uf));
    chk("sof_err", int'(sof_err), int'(m_se));
    if (busy) st_busy++;
    if (vsync) st_vs++;
    if (href) st_href++;
    if (frame_done) st_done++;
    if (pclk && href) cap.push_back(int'(d));
  endtask

  initial forever begin
    @(negedge clk);
    check_cycle();
  end

  task automatic snap_stats();
    b_busy = st_busy; b_vs = st_vs; b_href = st_href; b_done = st_done; b_cap = cap.size();
  endtask

  task automatic set_cfg(input int ha, input int hb, input int vs, input int vb, input int va, input int vf);
    h_active = HW'(ha); h_blank = HW'(hb); vsync_len = VW'(vs);
    v_back = VW'(vb); v_active = VW'(va); v_front = VW'(vf);
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (frame_done !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    chk({nm, "_timeout"}, int'(n < limit), 1);
  endtask

  task automatic one_frame(input string nm);
    @(negedge clk); #1;
    snap_stats();
    enable = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
    wait_done(nm, 400);
    @(negedge clk); #1;
  endtask

  task automatic check_frame(input string nm, input int busy_c, input int vs_c, input int href_c,
                             input int done_c, input int npix, input int per);
    int k;
    chk({nm, "_busy_cycles"}, st_busy - b_busy, busy_c);
    chk({nm, "_vsync_cycles"}, st_vs - b_vs, vs_c);
    chk({nm, "_href_cycles"}, st_href - b_href, href_c);
    chk({nm, "_done_pulses"}, st_done - b_done, done_c);
    chk({nm, "_pixel_count"}, cap.size() - b_cap, npix);
    for (int i = 0; i < npix && b_cap + i < cap.size(); i++) begin
      k = i % per;
      chk({nm, "_pixel"}, cap[b_cap + i], pix_valid(k) ? k + 1 : 0);
    end
  endtask

  initial begin
    int n;
    set_cfg(4, 2, 1, 1, 2, 1);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pclk", int'(pclk), 0);
    chk("rst_d", int'(d), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame: 5 lines x 12 clocks
    one_frame("basic");
    check_frame("basic", 60, 12, 16, 1, 8, 8);
    chk("basic_idle_busy", int'(busy), 0);
    chk("basic_idle_pclk", int'(pclk), 0);
    chk("basic_underflow", int'(underflow), 0);

    // underflow on pixel 3 of line 1
    drop_idx = 2;
    one_frame("uflow");
    check_frame("uflow", 60, 12, 16, 1, 8, 8);
    chk("uflow_sticky", int'(underflow), 1);
    repeat (5) @(negedge clk);
    chk("uflow_still", int'(underflow), 1);
    drop_idx = -1;

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("uflow_cleared", int'(underflow), 0);

    // enable held over two frames, dropped during frame 2 line 2
    @(negedge clk); #1;
    snap_stats();
    enable = 1'b1;
    wait_done("held_a", 400);
    chk("held_busy_at_done", int'(busy), 1);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    wait_done("held_b", 400);
    @(negedge clk); #1;
    check_frame("held", 120, 24, 32, 2, 16, 8);
    chk("held_idle_busy", int'(busy), 0);
    chk("held_idle_pclk", int'(pclk), 0);

    // zero-length phases, h_blank=0 acts as 1
    set_cfg(4, 0, 0, 0, 2, 0);
    one_frame("zero");
    check_frame("zero", 20, 0, 16, 1, 8, 8);

    // SOF asserted again on pixel 2
    set_cfg(4, 2, 1, 1, 2, 1);
    bad_sof_idx = 1;
    chk("sof_before", int'(sof_err), 0);
    one_frame("sof");
    check_frame("sof", 60, 12, 16, 1, 8, 8);
    chk("sof_err_set", int'(sof_err), 1);
    bad_sof_idx = -1;

    // asynchronous reset in the middle of ACTIVE
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (href !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("arst_reach_active", int'(n < 200), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_pclk", int'(pclk), 0);
    chk("arst_href", int'(href), 0);
    chk("arst_vsync", int'(vsync), 0);
    chk("arst_d", int'(d), 0);
    chk("arst_ready", int'(s_ready), 0);
    chk("arst_sof_err", int'(sof_err), 0);
    @(negedge clk); #1;
    snap_stats();
    rst_n = 1'b1;
    @(negedge clk); #1;
    enable = 1'b0;
    chk("arst_vsync_first", int'(busy), 1);
    wait_done("arst", 400);
    @(negedge clk); #1;
    check_frame("arst", 60, 12, 16, 1, 8, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
